// File: rtl/aes_load_sched.sv
// aes_load_sched: byte-serial load scheduler for the AES-256 input path.
// It arbitrates between the key requester (32 bytes) and the plaintext block
// requester (16 bytes), and grants one of them at a time to the shared row
// registers. For each granted transfer it sequences the row write strobe and
// the row select, then reports completion to the core with a one-cycle pulse.
// The ready, write-strobe, byte and row-select outputs are decoded
// combinationally from the registered state, the counter and the valid
// inputs. The completion pulses and the key-present level are registered.
module aes_load_sched #(
  parameter int KEY_BYTES = 32,
  parameter int BLK_BYTES = 16,
  parameter int ROW_BYTES = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_valid_i,
  input  logic [7:0] key_byte_i,
  output logic       key_ready_o,
  input  logic       dat_valid_i,
  input  logic [7:0] dat_byte_i,
  output logic       dat_ready_o,
  input  logic       core_busy_i,
  output logic       wr_en_o,
  output logic [7:0] byte_o,
  output logic [2:0] row_sel_o,
  output logic       tgt_key_o,
  output logic       key_loaded_o,
  output logic       blk_loaded_o,
  output logic       key_present_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEY  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Counter value of the last byte of each transfer type, and the row size.
  localparam logic [4:0] KEY_LAST_C = 5'(KEY_BYTES - 1);
  localparam logic [4:0] BLK_LAST_C = 5'(BLK_BYTES - 1);
  localparam logic [4:0] ROW_DIV_C  = 5'(ROW_BYTES);

  // Registered state.
  state_t     state_r;
  logic [4:0] cnt_r;
  logic       tgt_r;
  logic       key_present_r;
  logic       key_loaded_r;
  logic       blk_loaded_r;

  // Next-state and decoded signals.
  state_t     state_nxt_s;
  logic [4:0] cnt_nxt_s;
  logic       tgt_nxt_s;
  logic       key_present_nxt_s;
  logic       key_loaded_nxt_s;
  logic       blk_loaded_nxt_s;
  logic       key_ready_s;
  logic       dat_ready_s;
  logic       accept_s;
  logic [7:0] byte_s;
  logic [2:0] row_idx_s;

  // The row index is the byte index divided by the row size. A key index
  // never exceeds 31, so the quotient always fits in three bits.
  assign row_idx_s = 3'(cnt_r / ROW_DIV_C);

  // Arbitration, byte sequencing and completion handling.
  always_comb begin
    state_nxt_s       = state_r;
    cnt_nxt_s         = cnt_r;
    tgt_nxt_s         = tgt_r;
    key_present_nxt_s = key_present_r;
    key_loaded_nxt_s  = 1'b0;
    blk_loaded_nxt_s  = 1'b0;
    key_ready_s       = 1'b0;
    dat_ready_s       = 1'b0;
    accept_s          = 1'b0;
    byte_s            = 8'h00;
    case (state_r)
      ST_IDLE: begin
        // No new grant is made while the core is busy. Key has priority,
        // and data is only granted once a complete key is present.
        if (!core_busy_i) begin
          if (key_valid_i) begin
            state_nxt_s       = ST_KEY;
            cnt_nxt_s         = 5'd0;
            tgt_nxt_s         = 1'b1;
            key_present_nxt_s = 1'b0;
          end else if (dat_valid_i && key_present_r) begin
            state_nxt_s = ST_DATA;
            cnt_nxt_s   = 5'd0;
            tgt_nxt_s   = 1'b0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_KEY: begin
        key_ready_s = 1'b1;
        if (key_valid_i) begin
          accept_s = 1'b1;
          byte_s   = key_byte_i;
          if (cnt_r == KEY_LAST_C) begin
            state_nxt_s       = ST_DONE;
            cnt_nxt_s         = 5'd0;
            key_loaded_nxt_s  = 1'b1;
            key_present_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + 5'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_DATA: begin
        dat_ready_s = 1'b1;
        if (dat_valid_i) begin
          accept_s = 1'b1;
          byte_s   = dat_byte_i;
          if (cnt_r == BLK_LAST_C) begin
            state_nxt_s      = ST_DONE;
            cnt_nxt_s        = 5'd0;
            blk_loaded_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + 5'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_DONE: begin
        // The completion pulse is visible during this cycle.
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 5'd0;
      end
    endcase
  end

  // State register; reset discards any partial transfer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 5'd0;
      tgt_r         <= 1'b0;
      key_present_r <= 1'b0;
      key_loaded_r  <= 1'b0;
      blk_loaded_r  <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      tgt_r         <= tgt_nxt_s;
      key_present_r <= key_present_nxt_s;
      key_loaded_r  <= key_loaded_nxt_s;
      blk_loaded_r  <= blk_loaded_nxt_s;
    end
  end

  // Output drive; the row select is zero whenever no byte is being written.
  always_comb begin
    key_ready_o   = key_ready_s;
    dat_ready_o   = dat_ready_s;
    wr_en_o       = accept_s;
    byte_o        = byte_s;
    if (accept_s) begin
      row_sel_o = row_idx_s;
    end else begin
      row_sel_o = 3'd0;
    end
    tgt_key_o     = tgt_r;
    key_loaded_o  = key_loaded_r;
    blk_loaded_o  = blk_loaded_r;
    key_present_o = key_present_r;
  end

endmodule

// File: tb/tb_aes_load_sched.sv
// Directed, table-driven testbench for aes_load_sched. Each record holds the
// inputs for one clock cycle together with the outputs expected during that
// cycle. The main scenario is held in a table; the multi-cycle corner cases
// are written out as hand sequences.
module tb_aes_load_sched;

  logic       clk = 1'b0;
  logic       resetn;
  logic       key_valid_i;
  logic [7:0] key_byte_i;
  logic       key_ready_o;
  logic       dat_valid_i;
  logic [7:0] dat_byte_i;
  logic       dat_ready_o;
  logic       core_busy_i;
  logic       wr_en_o;
  logic [7:0] byte_o;
  logic [2:0] row_sel_o;
  logic       tgt_key_o;
  logic       key_loaded_o;
  logic       blk_loaded_o;
  logic       key_present_o;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic       kv;
    logic [7:0] kb;
    logic       dv;
    logic [7:0] db;
    logic       busy;
    logic       kr;
    logic       dr;
    logic       wr;
    logic [7:0] by;
    logic [2:0] row;
    logic       tgt;
    logic       kl;
    logic       bl;
    logic       kp;
  } vec_t;

  aes_load_sched dut (
    .clk           (clk),
    .resetn        (resetn),
    .key_valid_i   (key_valid_i),
    .key_byte_i    (key_byte_i),
    .key_ready_o   (key_ready_o),
    .dat_valid_i   (dat_valid_i),
    .dat_byte_i    (dat_byte_i),
    .dat_ready_o   (dat_ready_o),
    .core_busy_i   (core_busy_i),
    .wr_en_o       (wr_en_o),
    .byte_o        (byte_o),
    .row_sel_o     (row_sel_o),
    .tgt_key_o     (tgt_key_o),
    .key_loaded_o  (key_loaded_o),
    .blk_loaded_o  (blk_loaded_o),
    .key_present_o (key_present_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic kv, input logic [7:0] kb,
                              input logic dv, input logic [7:0] db,
                              input logic busy, input logic kr, input logic dr,
                              input logic wr, input logic [7:0] by,
                              input logic [2:0] row, input logic tgt,
                              input logic kl, input logic bl, input logic kp);
    vec_t v;
    v.kv = kv; v.kb = kb; v.dv = dv; v.db = db; v.busy = busy;
    v.kr = kr; v.dr = dr; v.wr = wr; v.by = by; v.row = row;
    v.tgt = tgt; v.kl = kl; v.bl = bl; v.kp = kp;
    return v;
  endfunction

  task automatic cmp(input string tag, input string what,
                     input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got 0x%02h, required 0x%02h", tag, what, act, exp);
    end
  endtask

  task automatic chk(input vec_t v, input string tag);
    cmp(tag, "key_ready",   {7'd0, key_ready_o},   {7'd0, v.kr});
    cmp(tag, "dat_ready",   {7'd0, dat_ready_o},   {7'd0, v.dr});
    cmp(tag, "wr_en",       {7'd0, wr_en_o},       {7'd0, v.wr});
    cmp(tag, "byte",        byte_o,                v.by);
    cmp(tag, "row_sel",     {5'd0, row_sel_o},     {5'd0, v.row});
    cmp(tag, "tgt_key",     {7'd0, tgt_key_o},     {7'd0, v.tgt});
    cmp(tag, "key_loaded",  {7'd0, key_loaded_o},  {7'd0, v.kl});
    cmp(tag, "blk_loaded",  {7'd0, blk_loaded_o},  {7'd0, v.bl});
    cmp(tag, "key_present", {7'd0, key_present_o}, {7'd0, v.kp});
  endtask

  task automatic drive(input vec_t v);
    key_valid_i = v.kv;
    key_byte_i  = v.kb;
    dat_valid_i = v.dv;
    dat_byte_i  = v.db;
    core_busy_i = v.busy;
  endtask

  // One clock cycle: apply inputs just after an edge, check mid-cycle,
  // then advance past the next rising edge.
  task automatic step(input vec_t v, input string tag);
    drive(v);
    #2;
    chk(v, tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    vec_t v;

    // Reset state, with both requesters active during reset.
    resetn = 1'b0;
    v = mk(1, 8'h33, 1, 8'h44, 0, 0, 0, 0, 8'h00, 3'd0, 0, 0, 0, 0);
    drive(v);
    repeat (2) @(posedge clk);
    #3;
    chk(v, "reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Table: data before key, busy in IDLE, key load with stall and busy,
    // then a data block.
    for (int i = 0; i < 50; i++)
      tbl.push_back(mk(0, 8'h00, 1, 8'h11, 0, 0, 0, 0, 8'h00, 3'd0, 0, 0, 0, 0));
    for (int i = 0; i < 2; i++)
      tbl.push_back(mk(1, 8'h00, 1, 8'h11, 1, 0, 0, 0, 8'h00, 3'd0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h00, 1, 8'h11, 0, 0, 0, 0, 8'h00, 3'd0, 0, 0, 0, 0));
    for (int i = 0; i < 32; i++) begin
      tbl.push_back(mk(1, 8'(i), 1, 8'h11, (i >= 5 && i < 8),
                       1, 0, 1, 8'(i), 3'(i / 4), 1, 0, 0, 0));
      if (i == 10) begin
        for (int s = 0; s < 5; s++)
          tbl.push_back(mk(0, 8'hEE, 1, 8'h11, 0, 1, 0, 0, 8'h00, 3'd0, 1, 0, 0, 0));
      end
    end
    tbl.push_back(mk(0, 8'h00, 1, 8'hAA, 0, 0, 0, 0, 8'h00, 3'd0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 8'hAA, 0, 0, 0, 0, 8'h00, 3'd0, 1, 0, 0, 1));
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(0, 8'h00, 1, 8'hAA, 0, 0, 1, 1, 8'hAA, 3'(i / 4), 0, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 3'd0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 3'd0, 0, 0, 0, 1));

    foreach (tbl[i]) step(tbl[i], $sformatf("tbl%0d", i));

    // Simultaneous request with a key present: the key is granted first,
    // and a key request made during the data transfer waits for it to end.
    step(mk(1, 8'h00, 1, 8'h00, 0, 0, 0, 0, 8'h00, 3'd0, 0, 0, 0, 1), "sim_grant");
    for (int i = 0; i < 32; i++)
      step(mk(1, 8'(8'h40 + i), 1, 8'h77, 0, 1, 0, 1, 8'(8'h40 + i), 3'(i / 4), 1, 0, 0, 0),
           $sformatf("sim_key%0d", i));
    step(mk(0, 8'h00, 1, 8'h80, 0, 0, 0, 0, 8'h00, 3'd0, 1, 1, 0, 1), "sim_kdone");
    step(mk(0, 8'h00, 1, 8'h80, 0, 0, 0, 0, 8'h00, 3'd0, 1, 0, 0, 1), "sim_dgrant");
    for (int i = 0; i < 16; i++)
      step(mk(1, 8'h99, 1, 8'(8'h80 + i), 1, 0, 1, 1, 8'(8'h80 + i), 3'(i / 4), 0, 0, 0, 1),
           $sformatf("sim_dat%0d", i));
    step(mk(1, 8'h5A, 0, 8'h00, 0, 0, 0, 0, 8'h00, 3'd0, 0, 0, 1, 1), "sim_ddone");
    step(mk(1, 8'h5A, 0, 8'h00, 0, 0, 0, 0, 8'h00, 3'd0, 0, 0, 0, 1), "sim_kgrant");

    // Reset in the middle of a key transfer, after 20 bytes.
    for (int i = 0; i < 20; i++)
      step(mk(1, 8'(8'h5A + i), 0, 8'h00, 0, 1, 0, 1, 8'(8'h5A + i), 3'(i / 4), 1, 0, 0, 0),
           $sformatf("rst_key%0d", i));
    v = mk(1, 8'h20, 1, 8'h21, 0, 0, 0, 0, 8'h00, 3'd0, 0, 0, 0, 0);
    drive(v);
    resetn = 1'b0;
    #1;
    chk(v, "rst_async");
    @(posedge clk);
    #1;
    chk(v, "rst_hold");
    resetn = 1'b1;

    // A full key load after the reset completes normally.
    step(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 3'd0, 0, 0, 0, 0), "rl_grant");
    for (int i = 0; i < 32; i++)
      step(mk(1, 8'(8'hC0 + i), 0, 8'h00, 0, 1, 0, 1, 8'(8'hC0 + i), 3'(i / 4), 1, 0, 0, 0),
           $sformatf("rl_key%0d", i));
    step(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 3'd0, 1, 1, 0, 1), "rl_done");
    step(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 3'd0, 1, 0, 0, 1), "rl_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
